// File: rtl/matrix_capture.sv
// matrix_capture: receive end of the LED-matrix row/column shift-register link.
// Oversamples the serial lines on clk, rebuilds the row and column chains,
// copies them to row_q/col_q on each latch-enable edge and decodes a single
// lit pixel back to (x, y).
module matrix_capture #(
    parameter int ROWS           = 16,
    parameter int COLS           = 16,
    parameter int ROW_ACTIVE_LOW = 0,
    parameter int COL_ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rclk,
    input  logic            rsdi,
    input  logic            cclk,
    input  logic            csdi,
    input  logic            le,
    input  logic            oeb,
    output logic [ROWS-1:0] row_q,
    output logic [COLS-1:0] col_q,
    output logic            latch_pulse,
    output logic [3:0]      x,
    output logic [3:0]      y,
    output logic            pos_valid,
    output logic            len_err
);

    // Bit positions of each pin inside the synchroniser vectors.
    localparam int I_RCLK = 0;
    localparam int I_RSDI = 1;
    localparam int I_CCLK = 2;
    localparam int I_CSDI = 3;
    localparam int I_LE   = 4;
    localparam int I_OEB  = 5;
    localparam int DEC_W  = 16;

    localparam logic       ROW_INV  = 1'(ROW_ACTIVE_LOW);
    localparam logic       COL_INV  = 1'(COL_ACTIVE_LOW);
    localparam logic [4:0] ROWS_CNT = 5'(ROWS);
    localparam logic [4:0] COLS_CNT = 5'(COLS);

    // Saturating increment for the 5-bit shift counters.
    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [DEC_W-1:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

    // Index of the highest set bit (the only one when v is one-hot).
    function automatic logic [3:0] onehot_index(input logic [DEC_W-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < DEC_W; i++) begin
            idx = v[i] ? 4'(i) : idx;
        end
        return idx;
    endfunction

    logic [5:0]      pins_s;
    logic [5:0]      s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic            rclk_rise_s, cclk_rise_s, le_rise_s;
    logic [ROWS-1:0] rsh_q, rsh_d, row_d, r_norm_s;
    logic [COLS-1:0] csh_q, csh_d, col_d, c_norm_s;
    logic [4:0]      rcnt_q, rcnt_d, rcnt_incl_s;
    logic [4:0]      ccnt_q, ccnt_d, ccnt_incl_s;
    logic            latch_pulse_q, latch_pulse_d;
    logic            len_err_q, len_err_d;
    logic            pos_valid_q, pos_valid_d;
    logic            decode_ok_s;
    logic [3:0]      x_q, x_d, y_q, y_d;
    logic            unused_s;

    assign pins_s = {oeb, le, csdi, cclk, rsdi, rclk};

    // Rising edges are seen one stage after the metastability pair; data is
    // taken from s2 so it has exactly the same delay as its clock.
    assign rclk_rise_s = s2_q[I_RCLK] & ~s3_q[I_RCLK];
    assign cclk_rise_s = s2_q[I_CCLK] & ~s3_q[I_CCLK];
    assign le_rise_s   = s2_q[I_LE]   & ~s3_q[I_LE];

    // The delay stage of the data and OEB lines has no consumer.
    assign unused_s = ^{s3_q[I_RSDI], s3_q[I_CSDI], s3_q[I_OEB]};

    // Three-stage pipeline for every input pin.
    always_comb begin
        s1_d = pins_s;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Shift chains and saturating bit counters; an LE edge restarts the count.
    always_comb begin
        if (rclk_rise_s) begin
            rsh_d       = {rsh_q[ROWS-2:0], s2_q[I_RSDI]};
            rcnt_incl_s = sat_inc(rcnt_q);
        end else begin
            rsh_d       = rsh_q;
            rcnt_incl_s = rcnt_q;
        end
        if (cclk_rise_s) begin
            csh_d       = {csh_q[COLS-2:0], s2_q[I_CSDI]};
            ccnt_incl_s = sat_inc(ccnt_q);
        end else begin
            csh_d       = csh_q;
            ccnt_incl_s = ccnt_q;
        end
        if (le_rise_s) begin
            rcnt_d = {4'd0, rclk_rise_s};
            ccnt_d = {4'd0, cclk_rise_s};
        end else begin
            rcnt_d = rcnt_incl_s;
            ccnt_d = ccnt_incl_s;
        end
    end

    // Latch transfer: copy the chains (including a same-cycle shift) and flag length errors.
    always_comb begin
        if (le_rise_s) begin
            row_d         = rsh_d;
            col_d         = csh_d;
            latch_pulse_d = 1'b1;
            len_err_d     = (rcnt_incl_s != ROWS_CNT) || (ccnt_incl_s != COLS_CNT);
        end else begin
            row_d         = row_q;
            col_d         = col_q;
            latch_pulse_d = 1'b0;
            len_err_d     = len_err_q;
        end
    end

    // Pixel decode on the next latched words; pos_valid also tracks OEB every cycle.
    always_comb begin
        r_norm_s    = row_d ^ {ROWS{ROW_INV}};
        c_norm_s    = col_d ^ {COLS{COL_INV}};
        decode_ok_s = is_onehot(16'(r_norm_s)) && is_onehot(16'(c_norm_s));
        if (decode_ok_s) begin
            x_d = onehot_index(16'(c_norm_s));
            y_d = onehot_index(16'(r_norm_s));
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
        pos_valid_d = decode_ok_s && !s2_q[I_OEB];
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q          <= 6'd0;
            s2_q          <= 6'd0;
            s3_q          <= 6'd0;
            rsh_q         <= '0;
            csh_q         <= '0;
            rcnt_q        <= 5'd0;
            ccnt_q        <= 5'd0;
            row_q         <= '0;
            col_q         <= '0;
            latch_pulse_q <= 1'b0;
            len_err_q     <= 1'b0;
            pos_valid_q   <= 1'b0;
            x_q           <= 4'd0;
            y_q           <= 4'd0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            rsh_q         <= rsh_d;
            csh_q         <= csh_d;
            rcnt_q        <= rcnt_d;
            ccnt_q        <= ccnt_d;
            row_q         <= row_d;
            col_q         <= col_d;
            latch_pulse_q <= latch_pulse_d;
            len_err_q     <= len_err_d;
            pos_valid_q   <= pos_valid_d;
            x_q           <= x_d;
            y_q           <= y_d;
        end
    end

    assign latch_pulse = latch_pulse_q;
    assign len_err     = len_err_q;
    assign pos_valid   = pos_valid_q;
    assign x           = x_q;
    assign y           = y_q;

endmodule

// File: doc/matrix_capture.md
Name: matrix_capture

Overview:
- Receive end of the LED-matrix shift-register interface driven by screen: RCLK/RSDI (row chain), CCLK/CSDI (column chain), LE, OEB.
- Oversamples the serial lines on the system clock and rebuilds the latched row and column words.
- Decodes a single lit pixel back to (x, y) coordinates.
- Used as an on-chip readback/self-check and as the bench model of the matrix hardware.

Parameters:
- ROWS, 16, row chain length in bits (≤16).
- COLS, 16, column chain length in bits (≤16).
- ROW_ACTIVE_LOW, 0, 1 = a row bit value of 0 means that row is driven.
- COL_ACTIVE_LOW, 0, 1 = a column bit value of 0 means that column is lit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- rclk  in  1  row shift clock (asynchronous to clk).
- rsdi  in  1  row serial data.
- cclk  in  1  column shift clock.
- csdi  in  1  column serial data.
- le  in  1  latch enable; rising edge transfers the shift chains to the outputs.
- oeb  in  1  output enable, active-low.
- row_q  out  ROWS  latched row word.
- col_q  out  COLS  latched column word.
- latch_pulse  out  1  one-cycle strobe when row_q/col_q update.
- x  out  4  column index of the decoded pixel.
- y  out  4  row index of the decoded pixel.
- pos_valid  out  1  decoded pixel valid and display enabled.
- len_err  out  1  last latch had a wrong shift count.

Behaviour:
- Sync: each of rclk, rsdi, cclk, csdi, le, oeb passes through two flops (s1, s2), then a third delay flop (s3).
  - Rising edge detected when s2=1 and s3=0.
  - Data is taken from s2 of the same chain, so data and clock see identical delay.
- Input timing:
  - Serial clock high and low phases ≥2 clk cycles each.
  - Data set up ≥1 cycle before and held ≥1 cycle after its clock edge at the pin.
- Shift on a detected rclk edge: rsh <= {rsh[ROWS-2:0], rsdi_s2}.
  - The first bit shifted ends at bit ROWS-1 after ROWS shifts.
  - The column chain (csh) is identical, clocked by cclk.
- Shift counters rcnt/ccnt (5 bits):
  - Increment on each shift; saturate at 31.
  - Clear on an LE edge. A shift in the same cycle as the LE edge counts as 1 (new chain).
- Latency: input edge to shift-register update = 3 clk cycles.
- LE edge (same 3-cycle latency), registered outputs on the next clock:
  - row_q <= rsh and col_q <= csh. A shift in the LE cycle is applied to rsh/csh before the copy.
  - latch_pulse = 1 for exactly 1 cycle.
  - len_err <= (rcnt_incl != ROWS) || (ccnt_incl != COLS), where *_incl includes a same-cycle shift.
- Decode, combinational on row_q/col_q, registered alongside them:
  - Normalise with the polarity parameters to active-high r, c.
  - one-hot(r) and one-hot(c) → y = index of r, x = index of c.
  - Otherwise x and y hold their previous value, and the decode is not one-hot.
- pos_valid = decode one-hot && oeb_s2 == 0.
  - Re-evaluated every cycle, so OEB going high deasserts it 3 cycles after the pin.
- le and oeb edges are independent; simultaneous events are all honoured in the same cycle.
- Reset (reset==0 at a clk edge):
  - All sync flops = 0.
  - rsh, csh, row_q, col_q = 0; rcnt, ccnt = 0; x, y = 0.
  - latch_pulse, pos_valid, len_err = 0.
  - Reset mid-shift discards the partial word; the first LE after reset reports len_err unless full chains were shifted.
- No handshake back to the transmitter; missed edges from clocks violating the phase rule are undefined.

Test Plan:
- Reset held 3 cycles with random serial toggling → every output 0; latch_pulse never asserts.
- Shift rows 0x0010 and cols 0x0200 MSB-first (16 bits each), pulse LE, OEB=0 → row_q=0x0010, col_q=0x0200, latch_pulse single cycle, y=4, x=9, pos_valid=1, len_err=0.
- Same frame, then OEB=1 → pos_valid falls 3 cycles after the pin edge; x=9, y=4 retained.
- Row 0x0011 (two bits) → latch_pulse=1, pos_valid=0, x/y unchanged from the previous frame.
- Only 15 column bits shifted before LE → len_err=1. Next correct 16/16 frame → len_err=0.
- ROW_ACTIVE_LOW=1, row word 0xFFFE, col 0x8000 → y=0, x=15, pos_valid=1. Also assert reset mid-shift at bit 7, then shift a full frame → correct word with no corruption from the partial shift.
